// File: rtl/cbud_timer_ctrl.sv
// rtl/cbud_timer_ctrl.sv - interval-timer sequencer for a CBUD-style up/down counter chain
//
// Drives the counter's control pins (LD/D, EN, DNUP, CAI, CS) and watches its
// Q and CAO to build a one-shot or periodic timer with a prescaled carry-in,
// pause, sticky interrupt and overrun flag.
//
// Optional feature macro: CBUD_TIMER_CAPTURE_EN (adds SNAP, CAPT, CAPT_VLD).
//
// Ports:
//   CLK       in   clock, rising edge
//   CDN       in   asynchronous active-low reset
//   START     in   host pulse: begin (or restart) a timing run
//   STOP      in   host pulse: abort and clear the counter
//   HOLD      in   level: pause counting
//   PERIODIC  in   level: 1 = auto-reload on terminal count, 0 = one-shot
//   DIR       in   direction, 0 = up, 1 = down; sampled on START
//   RELOAD    in   [WIDTH] load value
//   IRQ_ACK   in   host pulse: clear IRQ and OVR (and CAPT_VLD)
//   Q         in   [WIDTH] counter outputs
//   CAO       in   counter carry-out (terminal count)
//   LD        out  counter parallel load
//   D         out  [WIDTH] counter load data (RELOAD)
//   EN        out  counter enable
//   DNUP      out  counter direction
//   CAI       out  counter carry-in (prescaled tick)
//   CS        out  counter synchronous clear
//   BUSY      out  controller not idle
//   IRQ       out  sticky terminal-count flag
//   OVR       out  terminal count while IRQ already set
//   SNAP      in   (capture build) capture Q into CAPT
//   CAPT      out  (capture build) [WIDTH] captured count
//   CAPT_VLD  out  (capture build) CAPT holds a fresh value

module cbud_timer_ctrl #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 4,
    parameter int PS_W     = 16
) (
    input  logic             CLK,
    input  logic             CDN,
    input  logic             START,
    input  logic             STOP,
    input  logic             HOLD,
    input  logic             PERIODIC,
    input  logic             DIR,
    input  logic [WIDTH-1:0] RELOAD,
    input  logic             IRQ_ACK,
    input  logic [WIDTH-1:0] Q,
    input  logic             CAO,
`ifdef CBUD_TIMER_CAPTURE_EN
    input  logic             SNAP,
    output logic [WIDTH-1:0] CAPT,
    output logic             CAPT_VLD,
`endif
    output logic             LD,
    output logic [WIDTH-1:0] D,
    output logic             EN,
    output logic             DNUP,
    output logic             CAI,
    output logic             CS,
    output logic             BUSY,
    output logic             IRQ,
    output logic             OVR
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_LOAD  = 3'd2,
        S_RUN   = 3'd3,
        S_PAUSE = 3'd4
    } state_t;

    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1);

    state_t          state;
    state_t          state_nxt;
    logic [PS_W-1:0] ps;
    logic [PS_W-1:0] ps_nxt;

    logic ld_q;
    logic en_q;
    logic cai_q;
    logic cs_q;
    logic dnup_q;
    logic busy_q;
    logic irq_q;
    logic ovr_q;

    // Terminal event: the counter wrapped while we were running. STOP in the
    // same cycle wins, so the event is suppressed entirely.
    logic term;
    assign term = (state == S_RUN) && CAO && !STOP;

    // Next-state logic. STOP beats everything, then restart, then terminal.
    always_comb begin
        state_nxt = state;
        if (STOP) begin
            state_nxt = S_CLEAR;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (START) state_nxt = S_LOAD;
                end
                S_CLEAR: begin
                    state_nxt = S_IDLE;
                end
                S_LOAD: begin
                    state_nxt = S_RUN;
                end
                S_RUN: begin
                    if (START)                 state_nxt = S_LOAD;
                    else if (term && !PERIODIC) state_nxt = S_IDLE;
                    else if (HOLD)             state_nxt = S_PAUSE;
                end
                S_PAUSE: begin
                    if (START)      state_nxt = S_LOAD;
                    else if (!HOLD) state_nxt = S_RUN;
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Prescaler: cleared on LOAD, counts and wraps only while RUN, and holds
    // its value everywhere else so a pause resumes mid-period.
    always_comb begin
        ps_nxt = ps;
        if (state == S_LOAD) begin
            ps_nxt = '0;
        end else if (state == S_RUN) begin
            ps_nxt = (ps == PS_LAST) ? '0 : ps + PS_ONE;
        end
    end

    // Control outputs are registered from the next state / next prescaler so
    // that each one is valid for exactly the cycle its state is occupied.
    always_ff @(posedge CLK or negedge CDN) begin
        if (!CDN) begin
            state  <= S_IDLE;
            ps     <= '0;
            ld_q   <= 1'b0;
            en_q   <= 1'b0;
            cai_q  <= 1'b0;
            cs_q   <= 1'b0;
            dnup_q <= 1'b0;
            busy_q <= 1'b0;
            irq_q  <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            ps     <= ps_nxt;
            ld_q   <= (state_nxt == S_LOAD);
            en_q   <= (state_nxt == S_RUN) || (state_nxt == S_PAUSE);
            cai_q  <= (state_nxt == S_RUN) && (ps_nxt == PS_LAST);
            cs_q   <= (state_nxt == S_CLEAR);
            busy_q <= (state_nxt != S_IDLE);

            // LOAD is only ever entered from an accepted START.
            if (state_nxt == S_LOAD) begin
                dnup_q <= DIR;
            end

            // Set has priority over acknowledge for both flags.
            if (term) begin
                irq_q <= 1'b1;
            end else if (IRQ_ACK) begin
                irq_q <= 1'b0;
            end

            if (term && irq_q) begin
                ovr_q <= 1'b1;
            end else if (IRQ_ACK) begin
                ovr_q <= 1'b0;
            end
        end
    end

`ifdef CBUD_TIMER_CAPTURE_EN
    logic [WIDTH-1:0] capt_q;
    logic             capt_vld_q;

    // A terminal event captures the pre-reload count, as does a host SNAP.
    always_ff @(posedge CLK or negedge CDN) begin
        if (!CDN) begin
            capt_q     <= '0;
            capt_vld_q <= 1'b0;
        end else begin
            if (SNAP || term) begin
                capt_q     <= Q;
                capt_vld_q <= 1'b1;
            end else if (IRQ_ACK) begin
                capt_vld_q <= 1'b0;
            end
        end
    end

    assign CAPT     = capt_q;
    assign CAPT_VLD = capt_vld_q;
`endif

    // Periodic reload must land in the terminal cycle itself: the counter
    // prefers load over count, so the wrap value is never seen on Q.
    assign LD   = ld_q || (term && PERIODIC);
    assign D    = RELOAD;
    assign EN   = en_q;
    assign DNUP = dnup_q;
    assign CAI  = cai_q;
    assign CS   = cs_q;
    assign BUSY = busy_q;
    assign IRQ  = irq_q;
    assign OVR  = ovr_q;

endmodule

// File: tb/tb_cbud_timer_ctrl.sv
// tb/tb_cbud_timer_ctrl.sv - scoreboard bench for cbud_timer_ctrl with counter models attached
module tb_cbud_timer_ctrl;

    logic       CLK = 1'b0;
    logic       CDN = 1'b0;
    logic       START = 1'b0;
    logic       STOP = 1'b0;
    logic       HOLD = 1'b0;
    logic       PERIODIC = 1'b0;
    logic       DIR = 1'b0;
    logic       IRQ_ACK = 1'b0;
    logic [7:0] RELOAD = 8'h00;

    always #5 CLK = ~CLK;

    // instance a: PRESCALE=4, instance b: PRESCALE=1
    logic [7:0] q_a, d_a, q_b, d_b;
    logic cao_a, ld_a, en_a, dnup_a, cai_a, cs_a, busy_a, irq_a, ovr_a;
    logic cao_b, ld_b, en_b, dnup_b, cai_b, cs_b, busy_b, irq_b, ovr_b;
`ifdef CBUD_TIMER_CAPTURE_EN
    logic       snap = 1'b0;
    logic [7:0] capt_a, capt_b;
    logic       cv_a, cv_b;
`endif

    cbud_timer_ctrl #(.WIDTH(8), .PRESCALE(4), .PS_W(16)) u_dut_a (
        .CLK(CLK), .CDN(CDN), .START(START), .STOP(STOP), .HOLD(HOLD),
        .PERIODIC(PERIODIC), .DIR(DIR), .RELOAD(RELOAD), .IRQ_ACK(IRQ_ACK),
        .Q(q_a), .CAO(cao_a),
`ifdef CBUD_TIMER_CAPTURE_EN
        .SNAP(snap), .CAPT(capt_a), .CAPT_VLD(cv_a),
`endif
        .LD(ld_a), .D(d_a), .EN(en_a), .DNUP(dnup_a), .CAI(cai_a), .CS(cs_a),
        .BUSY(busy_a), .IRQ(irq_a), .OVR(ovr_a)
    );

    cbud_timer_ctrl #(.WIDTH(8), .PRESCALE(1), .PS_W(16)) u_dut_b (
        .CLK(CLK), .CDN(CDN), .START(START), .STOP(STOP), .HOLD(HOLD),
        .PERIODIC(PERIODIC), .DIR(DIR), .RELOAD(RELOAD), .IRQ_ACK(IRQ_ACK),
        .Q(q_b), .CAO(cao_b),
`ifdef CBUD_TIMER_CAPTURE_EN
        .SNAP(snap), .CAPT(capt_b), .CAPT_VLD(cv_b),
`endif
        .LD(ld_b), .D(d_b), .EN(en_b), .DNUP(dnup_b), .CAI(cai_b), .CS(cs_b),
        .BUSY(busy_b), .IRQ(irq_b), .OVR(ovr_b)
    );

    // Behavioural counter: clear > load > count; CAO qualified by CAI and EN.
    function automatic logic [7:0] cnt_next(input logic [7:0] q, input logic ld,
                                            input logic [7:0] d, input logic en,
                                            input logic dnup, input logic cai,
                                            input logic cs);
        if (cs) return 8'h00;
        if (ld) return d;
        if (en && cai) return dnup ? q - 8'd1 : q + 8'd1;
        return q;
    endfunction

    always_ff @(posedge CLK or negedge CDN) begin
        if (!CDN) begin
            q_a <= 8'h00;
            q_b <= 8'h00;
        end else begin
            q_a <= cnt_next(q_a, ld_a, d_a, en_a, dnup_a, cai_a, cs_a);
            q_b <= cnt_next(q_b, ld_b, d_b, en_b, dnup_b, cai_b, cs_b);
        end
    end

    assign cao_a = cai_a && en_a && (dnup_a ? (q_a == 8'h00) : (q_a == 8'hFF));
    assign cao_b = cai_b && en_b && (dnup_b ? (q_b == 8'h00) : (q_b == 8'hFF));

    int cyc = 0;
    always_ff @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    task automatic sb_push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic sb_pop_chk(input logic [31:0] got);
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_underflow", sb.size(), 1);
        end else begin
            e = sb.pop_front();
            chk(e.tag, got, e.val);
        end
    endtask

    task automatic sb_drain(input string tag);
        chk(tag, sb.size(), 0);
        sb.delete();
    endtask

    task automatic pulse_ack();
        IRQ_ACK = 1'b1;
        @(negedge CLK);
        IRQ_ACK = 1'b0;
    endtask

    task automatic do_stop();
        STOP = 1'b1;
        @(negedge CLK);
        STOP = 1'b0;
        @(negedge CLK);
    endtask

    task automatic do_start();
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  base;
        int  nterm;
        bit  got;
        bit  zero_seen;
        bit  moved;
        logic [7:0] held_q;

        // ---------------- reset state ----------------
        @(negedge CLK);
        chk("rst_outs_a", {ld_a, en_a, dnup_a, cai_a, cs_a, busy_a, irq_a, ovr_a}, 0);
        chk("rst_outs_b", {ld_b, en_b, dnup_b, cai_b, cs_b, busy_b, irq_b, ovr_b}, 0);
        CDN = 1'b1;
        @(negedge CLK);
        @(negedge CLK);

        // ---------------- one-shot down, PRESCALE=4 ----------------
        RELOAD = 8'd3; DIR = 1'b1; PERIODIC = 1'b0;
        do_start();
        chk("os_ld", ld_a, 1);
        chk("os_busy", busy_a, 1);
        base = cyc;
        for (int k = 1; k <= 4; k++) sb_push("os_cai_ofs", 4 * k);
        sb_push("os_cao_ofs", 16);
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge CLK);
            if (cai_a) sb_pop_chk(cyc - base);
            if (cao_a) begin
                sb_pop_chk(cyc - base);
                chk("os_dnup", dnup_a, 1);
                got = 1;
            end
        end
        if (!got) chk("os_timeout", got, 1);
        sb_drain("os_sb_drained");
        @(negedge CLK);
        chk("os_irq", irq_a, 1);
        chk("os_busy_after", busy_a, 0);
        chk("os_en_after", en_a, 0);
        chk("os_q_wrapped", q_a, 8'hFF);
        chk("os_ovr", ovr_a, 0);
        repeat (4) @(negedge CLK);

        // ---------------- periodic up, PRESCALE=1 ----------------
        pulse_ack();
        chk("pu_irq_acked", irq_b, 0);
        RELOAD = 8'hFC; DIR = 1'b0; PERIODIC = 1'b1;
        do_start();
        chk("pu_ld", ld_b, 1);
        base = cyc;
        sb_push("pu_term_ofs", 4);
        sb_push("pu_term_ofs", 8);
        sb_push("pu_term_ofs", 12);
        nterm = 0;
        zero_seen = 0;
        for (int i = 0; i < 30 && nterm < 3; i++) begin
            @(negedge CLK);
            if (q_b == 8'h00) zero_seen = 1;
            if (cyc - base == 5) begin
                chk("pu_irq_first", irq_b, 1);
                chk("pu_ovr_first", ovr_b, 0);
            end
            if (cao_b) begin
                sb_pop_chk(cyc - base);
                chk("pu_ld_with_cao", ld_b, 1);
                nterm++;
            end
        end
        if (nterm < 3) chk("pu_timeout", nterm, 3);
        sb_drain("pu_sb_drained");
        chk("pu_no_zero", zero_seen, 0);
        @(negedge CLK);
        chk("pu_q_reloaded", q_b, 8'hFC);
        chk("pu_ovr_set", ovr_b, 1);
        STOP = 1'b1;
        @(negedge CLK);
        STOP = 1'b0;
        chk("pu_cs", cs_b, 1);
        chk("pu_cs_ld", ld_b, 0);
        @(negedge CLK);
        chk("pu_q_cleared", q_b, 8'h00);
        chk("pu_idle", busy_b, 0);

        // ---------------- pause, PRESCALE=4 ----------------
        pulse_ack();
        RELOAD = 8'h10; DIR = 1'b0; PERIODIC = 1'b1;
        do_start();
        base = cyc;
        sb_push("pz_cai_ofs", 14);
        got = 0;
        moved = 0;
        held_q = 8'h00;
        for (int i = 1; i <= 20; i++) begin
            @(negedge CLK);
            if (i == 3) HOLD = 1'b1;
            if (i == 13) HOLD = 1'b0;
            if (i == 4) begin
                held_q = q_a;
                chk("pz_q_held", q_a, 8'h10);
            end
            if (i > 4 && i <= 13 && q_a != held_q) moved = 1;
            if (i == 8) begin
                chk("pz_en", en_a, 1);
                chk("pz_busy", busy_a, 1);
            end
            if (cai_a && !got) begin
                sb_pop_chk(i);
                got = 1;
            end
            if (i == 15) chk("pz_q_after", q_a, 8'h11);
        end
        if (!got) chk("pz_timeout", got, 1);
        sb_drain("pz_sb_drained");
        chk("pz_q_stable", moved, 0);
        do_stop();

        // ---------------- STOP coincident with CAO ----------------
        pulse_ack();
        RELOAD = 8'd1; DIR = 1'b1; PERIODIC = 1'b1;
        do_start();
        base = cyc;
        sb_push("sc_cao_ofs", 8);
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge CLK);
            if (cao_a) got = 1;
        end
        if (!got) chk("sc_timeout", got, 1);
        else sb_pop_chk(cyc - base);
        sb_drain("sc_sb_drained");
        STOP = 1'b1;
        @(negedge CLK);
        STOP = 1'b0;
        chk("sc_cs", cs_a, 1);
        chk("sc_ld", ld_a, 0);
        chk("sc_en", en_a, 0);
        chk("sc_irq", irq_a, 0);
        @(negedge CLK);
        chk("sc_cs_one_cycle", cs_a, 0);
        chk("sc_q", q_a, 8'h00);
        chk("sc_idle", busy_a, 0);
        chk("sc_irq_after", irq_a, 0);

        // ---------------- IRQ set vs ack, PRESCALE=1 ----------------
        pulse_ack();
        RELOAD = 8'd2; DIR = 1'b1; PERIODIC = 1'b1;
        do_start();
        base = cyc;
        sb_push("ack_t1_ofs", 3);
        sb_push("ack_t2_ofs", 6);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge CLK);
            if (cao_b) got = 1;
        end
        if (!got) chk("ack_t1_timeout", got, 1);
        else sb_pop_chk(cyc - base);
        IRQ_ACK = 1'b1;
        @(negedge CLK);
        IRQ_ACK = 1'b0;
        chk("ack_set_wins", irq_b, 1);
        chk("ack_ovr_clear", ovr_b, 0);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge CLK);
            if (cao_b) got = 1;
        end
        if (!got) chk("ack_t2_timeout", got, 1);
        else sb_pop_chk(cyc - base);
        sb_drain("ack_sb_drained");
        @(negedge CLK);
        chk("ack_ovr_set", ovr_b, 1);
        IRQ_ACK = 1'b1;
        @(negedge CLK);
        IRQ_ACK = 1'b0;
        chk("ack_irq_cleared", irq_b, 0);
        chk("ack_ovr_cleared", ovr_b, 0);
        do_stop();

        // ---------------- asynchronous reset mid-RUN ----------------
        RELOAD = 8'h40; DIR = 1'b1; PERIODIC = 1'b1;
        do_start();
        repeat (6) @(negedge CLK);
        chk("ar_running", {en_a, dnup_a, busy_a}, 3'b111);
        #2;
        CDN = 1'b0;
        #1;
        chk("ar_outs_a", {ld_a, en_a, dnup_a, cai_a, cs_a, busy_a, irq_a, ovr_a}, 0);
        chk("ar_outs_b", {ld_b, en_b, dnup_b, cai_b, cs_b, busy_b, irq_b, ovr_b}, 0);
        @(negedge CLK);
        CDN = 1'b1;
        @(negedge CLK);
        chk("ar_idle", busy_a, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cbud_timer_ctrl.md
Name: cbud_timer_ctrl

Overview:
- Sequencer that drives a cascadable up/down counter from the controlling end: generates LD/D, EN, DNUP, CAI and CS, and consumes the counter's Q and CAO.
- Turns the counter into a programmable interval timer: one-shot or periodic, with prescaled carry-in, pause, sticky interrupt and overrun flag.
- Sits between a host register interface and a CBUD-style counter chain. It is the controller a counter instance needs to be used as a timer.

Parameters:
WIDTH, 8, counter width in bits; the D and Q buses and RELOAD are WIDTH wide
PRESCALE, 4, CLK cycles per CAI pulse while running; legal range 1..65535
PS_W, 16, prescaler register width; must be at least ceil(log2(PRESCALE))

Ports:
CLK  in  1  clock, rising edge
CDN  in  1  asynchronous active-low reset (clear direct)
START  in  1  host pulse: begin a timing run
STOP  in  1  host pulse: abort and clear the counter
HOLD  in  1  level: pause counting
PERIODIC  in  1  level: 1 = auto-reload, 0 = one-shot
DIR  in  1  direction: 0 = up, 1 = down; sampled on START
RELOAD  in  WIDTH  load value
IRQ_ACK  in  1  host pulse: clear IRQ and OVR
Q  in  WIDTH  counter outputs
CAO  in  1  counter carry-out (terminal count, already qualified by CAI and EN)
LD  out  1  counter parallel load
D  out  WIDTH  counter load data, driven from RELOAD
EN  out  1  counter enable
DNUP  out  1  counter direction
CAI  out  1  counter carry-in
CS  out  1  counter synchronous clear
BUSY  out  1  state is not IDLE
IRQ  out  1  sticky terminal-count flag
OVR  out  1  terminal count occurred while IRQ was already set

Behaviour:
- Reset (CDN=0, asynchronous): state IDLE; prescaler 0; LD, EN, DNUP, CAI, CS, BUSY, IRQ and OVR all 0. Release is synchronous to CLK.
- States: IDLE, CLEAR, LOAD, RUN, PAUSE.
- IDLE:
  - EN=0, CAI=0.
  - START moves to LOAD; the DNUP register captures DIR.
- LOAD:
  - Exactly one cycle; LD=1, D=RELOAD; prescaler cleared to 0.
  - Next state is RUN.
- RUN:
  - EN=1.
  - Prescaler counts 0..PRESCALE-1 and wraps.
  - CAI=1 only in the cycle where the prescaler equals PRESCALE-1. With PRESCALE=1, CAI=1 in every RUN cycle.
  - HOLD=1 moves to PAUSE.
- PAUSE:
  - EN=1, CAI=0; prescaler frozen.
  - HOLD=0 returns to RUN and the prescaler resumes from its held value.
- Terminal event = RUN and CAO=1:
  - PERIODIC=1: LD=1 combinationally in the same cycle. The counter gives load priority over count, so RELOAD replaces the wrap value with no gap. Period is (RELOAD+1)*PRESCALE cycles when counting down to 0, and (2^WIDTH-RELOAD)*PRESCALE when counting up to all-ones. State stays RUN.
  - PERIODIC=0: next state is IDLE; the counter holds its wrapped value.
- IRQ: set on a terminal event; cleared by IRQ_ACK. If set and ack happen in the same cycle, set wins.
- OVR: set on a terminal event while IRQ is already 1; cleared by IRQ_ACK. Set wins over ack, as for IRQ.
- STOP from any state goes to CLEAR.
  - CLEAR lasts one cycle: CS=1, EN=0, then IDLE.
  - STOP takes priority over START, HOLD and any terminal event in the same cycle: no IRQ is set in that cycle.
- START in RUN or PAUSE restarts: go to LOAD, recapture DIR. IRQ and OVR are unaffected.
- LD and CS are never both 1.
- CAI is never 1 while EN=0.
- BUSY is a registered function of the next state.

Optional Feature:
- Macro: CBUD_TIMER_CAPTURE_EN.
- When defined:
  - Adds input SNAP (1 bit) and outputs CAPT (WIDTH) and CAPT_VLD (1 bit).
  - SNAP=1 registers Q into CAPT at the next edge and sets CAPT_VLD. CAPT_VLD is cleared by IRQ_ACK.
  - A terminal event in RUN also captures Q, i.e. the pre-reload count.
  - CAPT and CAPT_VLD reset to 0.
- When undefined: the ports are absent and there are no capture registers.

Test Plan:
- Reset with outputs disturbed: CDN=0 mid-RUN -> all outputs 0 immediately, state IDLE.
- One-shot down: RELOAD=3, PRESCALE=4, DIR=1, PERIODIC=0, START, with a behavioural counter model attached -> CAI every 4th cycle; CAO after 4 CAI pulses; IRQ=1; BUSY=0 next cycle; EN=0.
- Periodic up: RELOAD=8'hFC, PRESCALE=1, DIR=0, PERIODIC=1 -> LD pulses coincide with CAO every 4 cycles; no Q=00 cycle ever seen; second terminal without ack sets OVR=1.
- Pause: HOLD=1 for 10 cycles at prescaler=2 -> CAI=0 and Q stable; after release, the next CAI arrives 1 cycle later.
- STOP and CAO in the same cycle -> CS=1 for one cycle, IRQ stays 0, state IDLE, Q=0.
- IRQ set and IRQ_ACK in the same cycle -> IRQ remains 1; a following ack alone clears IRQ and OVR.
